// File: rtl/wb_sram_slave.sv
// Wishbone B4 slave backed by an on-chip word memory.
// Classic cycles take two clocks each; incrementing bursts stream one word per clock.
module wb_sram_slave #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0,
    parameter int                       MEM_WORDS     = 1024
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    output logic                       ACK,
    output logic                       ERR
);
    localparam int LANES     = WB_DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int IW        = $clog2(MEM_WORDS);
    localparam logic [WB_ADDR_WIDTH-1:0] DEPTH = WB_ADDR_WIDTH'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERROR} state_t;

    state_t state, state_next;

    logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [WB_ADDR_WIDTH-1:0] off;
    logic [WB_ADDR_WIDTH-1:0] word_off;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            cur_idx;
    logic [IW-1:0]            inc_idx;
    logic [IW-1:0]            wrap_mask;
    logic [IW-1:0]            next_idx;
    logic                     in_range;
    logic                     lin_over;
    logic                     ack_q;
    logic                     err_q;
    logic                     ack_now;
    logic                     start;
    logic                     advance;
    logic                     wr_en;

    assign off      = ADR - ADDR_BASE;
    assign word_off = off >> LANE_BITS;
    assign idx      = word_off[IW-1:0];
    assign in_range = (ADR >= ADDR_BASE) && (word_off < DEPTH);

    assign ack_now = ack_q & CYC & STB;
    assign ACK     = ack_now;
    assign ERR     = err_q & CYC & STB;

    // Wrap bursts only advance the low bits inside the N-word block; linear uses a full mask.
    always_comb begin
        wrap_mask = '1;
        case (BTE)
            2'b01:   wrap_mask = IW'(3);
            2'b10:   wrap_mask = IW'(7);
            2'b11:   wrap_mask = IW'(15);
            default: wrap_mask = '1;
        endcase
    end

    assign inc_idx  = cur_idx + IW'(1);
    assign next_idx = (cur_idx & ~wrap_mask) | (inc_idx & wrap_mask);
    assign lin_over = (BTE == 2'b00) && (&cur_idx);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        advance    = 1'b0;
        wr_en      = 1'b0;
        if (!CYC) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (STB) begin
                        if (!in_range) begin
                            state_next = ERROR;
                        end else begin
                            start      = 1'b1;
                            state_next = (CTI == 3'b010) ? BURST : SINGLE;
                        end
                    end
                end
                SINGLE: begin
                    wr_en      = ack_now & WE;
                    state_next = IDLE;
                end
                BURST: begin
                    if (ack_now) begin
                        wr_en   = WE;
                        advance = 1'b1;
                        if (CTI == 3'b111) begin
                            state_next = IDLE;
                        end else if (lin_over) begin
                            state_next = ERROR;
                        end
                    end
                end
                ERROR: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Read data is fetched one beat ahead so it is already valid in the cycle the beat is acknowledged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            DAT_R   <= '0;
            cur_idx <= '0;
        end else begin
            ack_q <= (state_next == SINGLE) || (state_next == BURST);
            err_q <= (state_next == ERROR);
            if (state_next == ERROR) begin
                DAT_R <= '0;
            end else if (start) begin
                cur_idx <= idx;
                DAT_R   <= mem[idx];
            end else if (advance) begin
                cur_idx <= next_idx;
                DAT_R   <= mem[next_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && SEL[i]) begin
                mem[cur_idx][8*i +: 8] <= DAT_W[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomized self-checking bench for wb_sram_slave against a word-array reference model.
module tb_wb_sram_slave;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic [3:0]  SEL;
    logic [2:0]  CTI;
    logic [1:0]  BTE;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] DAT_R;
    logic        ACK;
    logic        ERR;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] ref_mem [MW];
    logic [31:0] rd;
    logic [2:0]  classic_ctis [4] = '{3'b000, 3'b111, 3'b001, 3'b100};

    wb_sram_slave #(
        .WB_ADDR_WIDTH(AW),
        .WB_DATA_WIDTH(DW),
        .ADDR_BASE    (BASE),
        .MEM_WORDS    (MW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .ADR  (ADR),
        .DAT_W(DAT_W),
        .SEL  (SEL),
        .CTI  (CTI),
        .BTE  (BTE),
        .CYC  (CYC),
        .STB  (STB),
        .WE   (WE),
        .DAT_R(DAT_R),
        .ACK  (ACK),
        .ERR  (ERR)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti,
                                 input logic [1:0] bte);
        CYC   = cyc;
        STB   = stb;
        WE    = we;
        ADR   = adr;
        DAT_W = dat;
        SEL   = sel;
        CTI   = cti;
        BTE   = bte;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wordAddr(input int idx);
        return BASE + 32'(idx) * 32'd4 + 32'($urandom_range(3));
    endfunction

    function automatic bit inRange(input logic [31:0] adr);
        return (adr >= BASE) && (((adr - BASE) / 4) < MW);
    endfunction

    // Next word of an incrementing burst: wrap-N stays inside its aligned N-word block.
    function automatic int nextIndex(input int idx, input logic [1:0] bte);
        int n;
        n = (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : (bte == 2'b11) ? 16 : 0;
        if (n == 0) return idx + 1;
        return (idx / n) * n + (idx + 1) % n;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    task automatic classicAccess(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                                 input logic [3:0] sel, input logic [2:0] cti, output logic [31:0] rdata);
        int lat;
        bit inr;
        int widx;
        inr  = inRange(adr);
        widx = inr ? int'((adr - BASE) / 4) : 0;
        applyStimulus(1'b1, 1'b1, we, adr, wdata, sel, cti, 2'($urandom));
        #1;
        checkOutput("classic_wait_ack", 32'(ACK | ERR), 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
            #1;
        end while (!(ACK || ERR) && lat < 4);
        checkOutput("classic_latency", 32'(lat), 32'd1);
        checkOutput("classic_ack", 32'(ACK), 32'(inr));
        checkOutput("classic_err", 32'(ERR), 32'(!inr));
        rdata = DAT_R;
        if (!inr) begin
            checkOutput("classic_err_dat", DAT_R, 32'd0);
        end else if (!we) begin
            checkOutput("classic_rdata", DAT_R, ref_mem[widx]);
        end
        tick();
        #1;
        checkOutput("classic_one_cycle", 32'(ACK | ERR), 32'd0);
        if (we && inr) ref_mem[widx] = mergeBytes(ref_mem[widx], wdata, sel);
        applyStimulus(1'b0, 1'b0, 1'b0, adr, 32'd0, 4'h0, 3'b000, 2'b00);
    endtask

    task automatic burstAccess(input logic we, input int start, input logic [1:0] bte, input int nbeats,
                               input int stall_pct, input int stall_beat);
        int          idx;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [2:0]  cti;
        idx = start;
        applyStimulus(1'b1, 1'b1, we, wordAddr(idx), 32'($urandom), 4'hF, 3'b010, bte);
        #1;
        checkOutput("burst_first_wait", 32'(ACK | ERR), 32'd0);
        for (int b = 0; b < nbeats; b++) begin
            tick();
            if (idx < MW && (b == stall_beat || int'($urandom_range(99)) < stall_pct)) begin
                STB = 1'b0;
                #1;
                checkOutput("burst_stall_ack", 32'(ACK | ERR), 32'd0);
                checkOutput("burst_stall_hold", DAT_R, ref_mem[idx]);
                tick();
            end
            wdata = $urandom;
            sel   = 4'($urandom);
            cti   = (b == nbeats - 1) ? 3'b111 : 3'b010;
            applyStimulus(1'b1, 1'b1, we, wordAddr(idx), wdata, sel, cti, bte);
            #1;
            if (idx >= MW) begin
                checkOutput("burst_overrun_err", 32'(ERR), 32'd1);
                checkOutput("burst_overrun_ack", 32'(ACK), 32'd0);
                checkOutput("burst_overrun_dat", DAT_R, 32'd0);
                break;
            end
            checkOutput("burst_ack", 32'(ACK), 32'd1);
            checkOutput("burst_err", 32'(ERR), 32'd0);
            if (!we) checkOutput("burst_rdata", DAT_R, ref_mem[idx]);
            else ref_mem[idx] = mergeBytes(ref_mem[idx], wdata, sel);
            idx = nextIndex(idx, bte);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, wordAddr(0), 32'd0, 4'hF, 3'b000, 2'b00);
        #1;
        checkOutput("burst_end_idle", 32'(ACK | ERR), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, wordAddr(0), 32'd0, 4'h0, 3'b000, 2'b00);
    endtask

    task automatic resetMidBurst();
        applyStimulus(1'b1, 1'b1, 1'b0, wordAddr(8), 32'd0, 4'hF, 3'b010, 2'b00);
        tick();
        tick();
        tick();
        #1;
        checkOutput("rst_pre_ack", 32'(ACK), 32'd1);
        checkOutput("rst_pre_dat", DAT_R, ref_mem[10]);
        rstn = 1'b0;
        #1;
        checkOutput("rst_async_ack", 32'(ACK), 32'd0);
        checkOutput("rst_async_err", 32'(ERR), 32'd0);
        checkOutput("rst_async_dat", DAT_R, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 3'b000, 2'b00);
        tick();
        rstn = 1'b1;
        tick();
        classicAccess(1'b0, BASE + 32'h10, 32'd0, 4'hF, 3'b000, rd);
        checkOutput("rst_data_intact", rd, 32'hDEADBEEF);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int op;
        int widx;
        rstn = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, BASE, 32'd0, 4'hF, 3'b000, 2'b00);
        #12;
        checkOutput("reset_ack", 32'(ACK), 32'd0);
        checkOutput("reset_err", 32'(ERR), 32'd0);
        checkOutput("reset_dat", DAT_R, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, BASE, 32'd0, 4'h0, 3'b000, 2'b00);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        for (int i = 0; i < MW; i++) begin
            classicAccess(1'b1, wordAddr(i), $urandom, 4'hF, 3'b000, rd);
        end

        classicAccess(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd);
        classicAccess(1'b0, BASE + 32'h10, 32'd0, 4'hF, 3'b000, rd);
        checkOutput("deadbeef_readback", rd, 32'hDEADBEEF);

        classicAccess(1'b1, wordAddr(20), 32'h11223344, 4'hF, 3'b000, rd);
        classicAccess(1'b1, wordAddr(20), 32'h0000AA00, 4'b0010, 3'b000, rd);
        classicAccess(1'b0, wordAddr(20), 32'd0, 4'hF, 3'b000, rd);
        checkOutput("byte_enable_readback", rd, 32'h1122AA44);

        for (int i = 0; i < 4; i++) begin
            classicAccess(1'b1, wordAddr(i), 32'(i), 4'hF, 3'b000, rd);
        end
        burstAccess(1'b0, 0, 2'b00, 4, 0, -1);
        burstAccess(1'b0, 6, 2'b01, 4, 0, 2);

        classicAccess(1'b1, BASE + 32'(MW * 4), 32'hBAD0BAD0, 4'hF, 3'b000, rd);
        classicAccess(1'b0, wordAddr(0), 32'd0, 4'hF, 3'b000, rd);
        burstAccess(1'b0, MW - 2, 2'b00, 4, 0, -1);

        resetMidBurst();

        for (int it = 0; it < 40; it++) begin
            op   = int'($urandom_range(5));
            widx = int'($urandom_range(MW - 1));
            case (op)
                0, 1: classicAccess(1'b1, wordAddr(widx), $urandom, 4'($urandom),
                                    classic_ctis[$urandom_range(3)], rd);
                2: classicAccess(1'b0, wordAddr(widx), 32'd0, 4'hF, classic_ctis[$urandom_range(3)], rd);
                3: begin
                    if ($urandom_range(1) == 1)
                        classicAccess(1'($urandom), BASE + 32'(MW * 4) + 32'($urandom_range(1023)),
                                      $urandom, 4'hF, 3'b000, rd);
                    else
                        classicAccess(1'($urandom), BASE - 32'd4 - 32'($urandom_range(255)),
                                      $urandom, 4'hF, 3'b000, rd);
                end
                default: burstAccess(1'($urandom), widx, 2'($urandom), int'($urandom_range(2, 12)), 25, -1);
            endcase
        end

        for (int i = 0; i < MW; i += 7) begin
            classicAccess(1'b0, wordAddr(i), 32'd0, 4'hF, 3'b000, rd);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
